// File: rtl/soc_system_clkgen_pkg.sv
// Shared types and helpers for the digital clock generator: FSM states, per-channel
// configuration record and the counter preload rule.
package soc_system_clkgen_pkg;

    // Config fields are carried at a fixed width; DW must not exceed this.
    localparam int unsigned CFG_W      = 16;
    localparam int unsigned LOCK_CNT_W = 16;

    typedef enum logic [1:0] {
        HOLD,
        LOCK_WAIT,
        LOCKED,
        APPLY
    } state_e;

    typedef struct packed {
        logic [CFG_W-1:0] div;
        logic [CFG_W-1:0] high;
        logic [CFG_W-1:0] phase;
    } chan_cfg_t;

    // Counter start value so that a channel with phase p rises p cycles after a phase-0 one.
    function automatic logic [CFG_W-1:0] preload(chan_cfg_t cfg);
        if (cfg.div < CFG_W'(2) || cfg.phase == '0 || cfg.phase >= cfg.div) begin
            return '0;
        end
        return cfg.div - cfg.phase;
    endfunction

endpackage

// File: rtl/soc_system_clkgen_chan.sv
// One divided-clock channel: wrapping counter with preload, registered outclk and
// period-start pulse.
module soc_system_clkgen_chan
    import soc_system_clkgen_pkg::*;
(
    input  logic      refclk,
    input  logic      rst_n,
    input  logic      run,
    input  logic      restart,
    input  chan_cfg_t cfg,
    output logic      outclk,
    output logic      outclk_en
);

    logic [CFG_W-1:0] cnt_q, cnt_d;
    logic             clk_d, en_d;

    always_comb begin
        cnt_d = cnt_q;
        clk_d = 1'b0;
        en_d  = 1'b0;
        // div below 2 disables the channel outright.
        if ((run || restart) && cfg.div >= CFG_W'(2)) begin
            if (restart) begin
                cnt_d = preload(cfg);
            end else if (cnt_q >= cfg.div - CFG_W'(1)) begin
                cnt_d = '0;
            end else begin
                cnt_d = cnt_q + CFG_W'(1);
            end
            clk_d = (cnt_d < cfg.high);
            en_d  = (cnt_d == '0);
        end
    end

    always_ff @(posedge refclk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q     <= '0;
            outclk    <= 1'b0;
            outclk_en <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            outclk    <= clk_d;
            outclk_en <= en_d;
        end
    end

endmodule

// File: rtl/soc_system_clkgen.sv
// Clock generator top: sequencing FSM, shadow configuration, write handshake and the
// per-channel dividers.
module soc_system_clkgen
    import soc_system_clkgen_pkg::*;
#(
    parameter int unsigned NUM_CLOCKS         = 2,
    parameter int unsigned DW                 = 8,
    parameter int unsigned DEFAULT_DIV        = 4,
    parameter int unsigned DEFAULT_HIGH       = 2,
    parameter int unsigned DEFAULT_PHASE_STEP = 1,
    parameter int unsigned LOCK_CYCLES        = 16,
    localparam int unsigned CW = (NUM_CLOCKS > 1) ? $clog2(NUM_CLOCKS) : 1
) (
    input  logic                  refclk,
    input  logic                  rst_n,
    input  logic                  enable,
    input  logic                  cfg_valid,
    output logic                  cfg_ready,
    input  logic [CW-1:0]         cfg_chan,
    input  logic [DW-1:0]         cfg_div,
    input  logic [DW-1:0]         cfg_high,
    input  logic [DW-1:0]         cfg_phase,
    output logic [NUM_CLOCKS-1:0] outclk,
    output logic [NUM_CLOCKS-1:0] outclk_en,
    output logic                  locked
);

    localparam int unsigned DIV_MOD = (DEFAULT_DIV == 0) ? 1 : DEFAULT_DIV;

    function automatic chan_cfg_t default_cfg(int unsigned idx);
        chan_cfg_t c;
        c.div   = CFG_W'(DEFAULT_DIV);
        c.high  = CFG_W'(DEFAULT_HIGH);
        c.phase = CFG_W'((idx * DEFAULT_PHASE_STEP) % DIV_MOD);
        return c;
    endfunction

    state_e                state_q, state_d;
    logic [LOCK_CNT_W-1:0] lock_cnt_q, lock_cnt_d;
    logic                  ready_q;
    chan_cfg_t             shadow_q [NUM_CLOCKS];
    chan_cfg_t             wr_cfg;
    logic                  accept, chan_ok, run, restart;

    assign accept       = cfg_valid && cfg_ready;
    assign chan_ok      = (32'(cfg_chan) < NUM_CLOCKS);
    assign wr_cfg.div   = CFG_W'(cfg_div);
    assign wr_cfg.high  = CFG_W'(cfg_high);
    assign wr_cfg.phase = CFG_W'(cfg_phase);

    always_ff @(posedge refclk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= HOLD;
            lock_cnt_q <= '0;
            ready_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            lock_cnt_q <= lock_cnt_d;
            ready_q    <= 1'b1;
        end
    end

    always_comb begin
        state_d = state_q;
        if (!enable) begin
            state_d = HOLD;
        end else begin
            unique case (state_q)
                HOLD:      state_d = LOCK_WAIT;
                LOCK_WAIT: if (lock_cnt_q == LOCK_CNT_W'(LOCK_CYCLES - 1)) state_d = LOCKED;
                LOCKED:    if (accept && chan_ok) state_d = APPLY;
                APPLY:     state_d = LOCK_WAIT;
            endcase
        end
        lock_cnt_d = (state_q == LOCK_WAIT && state_d == LOCK_WAIT) ?
                     lock_cnt_q + LOCK_CNT_W'(1) : '0;
    end

    // Channel controls follow the next state so outputs change on the transition edge.
    always_comb begin
        cfg_ready = ready_q && (state_q == HOLD || state_q == LOCKED);
        locked    = (state_q == LOCKED);
        run       = (state_d == LOCK_WAIT || state_d == LOCKED);
        restart   = (state_d == LOCK_WAIT) && (state_q != LOCK_WAIT);
    end

    always_ff @(posedge refclk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < NUM_CLOCKS; i++) shadow_q[i] <= default_cfg(i);
        end else if (accept && chan_ok) begin
            for (int unsigned i = 0; i < NUM_CLOCKS; i++) begin
                if (cfg_chan == CW'(i)) shadow_q[i] <= wr_cfg;
            end
        end
    end

    for (genvar g = 0; g < NUM_CLOCKS; g++) begin : g_chan
        soc_system_clkgen_chan u_chan (
            .refclk    (refclk),
            .rst_n     (rst_n),
            .run       (run),
            .restart   (restart),
            .cfg       (shadow_q[g]),
            .outclk    (outclk[g]),
            .outclk_en (outclk_en[g])
        );
    end

endmodule
